// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA timing generator. Free-running pixel/line counters produce
// x/y plus undelayed decodes (active, line_start, frame_start) for the pixel
// generator. Raw de/hsync/vsync are delayed PIX_LAT clocks to line up with the
// generator's colour output, then registered together with the gated RGB so
// every DAC-side output lands PIX_LAT+1 clocks after its counter cycle.
//
// Optional feature macro: TEST_PATTERN_EN
//   defined   -> test_mode=1 replaces r_int/g_int/b_int with 8 colour bars
//   undefined -> test_mode is ignored
//
// Ports:
//   vgaclk                  pixel clock
//   reset                   synchronous, active-high reset
//   r_int/g_int/b_int [7:0] generator colour, PIX_LAT clocks after x/y
//   test_mode               colour-bar select (TEST_PATTERN_EN builds only)
//   x, y [CW-1:0]           current pixel coordinate (registered counters)
//   active                  inside visible region, undelayed
//   line_start              hcnt == 0
//   frame_start             hcnt == 0 and vcnt == 0
//   hsync, vsync            syncs at configured polarity, pipeline-aligned
//   sync_b                  active-low composite sync, pipeline-aligned
//   blank_b                 high in visible region, aligned with r/g/b
//   r, g, b [7:0]           registered DAC colour, zero while blanked
//   frame_count [15:0]      completed frames, wraps silently
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int PIX_LAT   = 2,
  parameter int CW        = 10
) (
  input  logic          vgaclk,
  input  logic          reset,
  input  logic [7:0]    r_int,
  input  logic [7:0]    g_int,
  input  logic [7:0]    b_int,
  input  logic          test_mode,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          active,
  output logic          line_start,
  output logic          frame_start,
  output logic          hsync,
  output logic          vsync,
  output logic          sync_b,
  output logic          blank_b,
  output logic [7:0]    r,
  output logic [7:0]    g,
  output logic [7:0]    b,
  output logic [15:0]   frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SS     = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SE     = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SS     = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SE     = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          HS_ON    = 1'(HSYNC_POL);
  localparam logic          VS_ON    = 1'(VSYNC_POL);

  // Delay-line word: {de, hs, vs} with syncs stored active-true, plus the
  // colour-bar value when the test pattern is built in.
`ifdef TEST_PATTERN_EN
  localparam int PW = 27;
`else
  localparam int PW = 3;
`endif

  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [CW-1:0] vcnt_q, vcnt_d;
  logic [15:0]   fc_q, fc_d;
  logic          de_raw_s, hs_raw_s, vs_raw_s;
  logic [PW-1:0] raw_s, tap_s;
  logic [23:0]   colour_s;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          sync_b_q, sync_b_d, blank_b_q, blank_b_d;
  logic [23:0]   rgb_q, rgb_d;

  // Next-state for pixel, line and frame counters.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    fc_d   = fc_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = CNT_ZERO;
      if (vcnt_q == V_LAST) begin
        vcnt_d = CNT_ZERO;
        fc_d   = fc_q + 16'd1;
      end else begin
        vcnt_d = vcnt_q + CNT_ONE;
      end
    end else begin
      hcnt_d = hcnt_q + CNT_ONE;
    end
  end

  // Counter registers.
  always_ff @(posedge vgaclk) begin
    if (reset) begin
      hcnt_q <= CNT_ZERO;
      vcnt_q <= CNT_ZERO;
      fc_q   <= 16'd0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      fc_q   <= fc_d;
    end
  end

  assign de_raw_s    = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  assign hs_raw_s    = (hcnt_q >= H_SS) && (hcnt_q < H_SE);
  assign vs_raw_s    = (vcnt_q >= V_SS) && (vcnt_q < V_SE);
  assign active      = de_raw_s;
  assign line_start  = (hcnt_q == CNT_ZERO);
  assign frame_start = (hcnt_q == CNT_ZERO) && (vcnt_q == CNT_ZERO);
  assign x           = hcnt_q;
  assign y           = vcnt_q;
  assign frame_count = fc_q;

`ifdef TEST_PATTERN_EN
  localparam logic [CW-1:0] BAR_W = CW'(H_ACTIVE / 8);
  logic [2:0] bar_idx_s;
  // Only the low 3 bits matter: outside the visible area the colour is blanked.
  assign bar_idx_s = 3'(hcnt_q / BAR_W);
  assign raw_s = {de_raw_s, hs_raw_s, vs_raw_s,
                  {8{bar_idx_s[2]}}, {8{bar_idx_s[1]}}, {8{bar_idx_s[0]}}};
`else
  logic unused_test_mode_s;
  assign unused_test_mode_s = test_mode;
  assign raw_s = {de_raw_s, hs_raw_s, vs_raw_s};
`endif

  // PIX_LAT-deep alignment delay; with PIX_LAT=0 the output stage taps the
  // raw decode directly.
  if (PIX_LAT == 0) begin : g_no_delay
    assign tap_s = raw_s;
  end else begin : g_delay
    logic [PW-1:0] dl_q [PIX_LAT];
    logic [PW-1:0] dl_d [PIX_LAT];

    // Shift the decoded word one stage per clock.
    always_comb begin
      dl_d[0] = raw_s;
      for (int i = 1; i < PIX_LAT; i++) begin
        dl_d[i] = dl_q[i-1];
      end
    end

    // Delay-line registers; reset clears de and deasserts both syncs.
    always_ff @(posedge vgaclk) begin
      if (reset) begin
        for (int i = 0; i < PIX_LAT; i++) begin
          dl_q[i] <= {PW{1'b0}};
        end
      end else begin
        dl_q <= dl_d;
      end
    end

    assign tap_s = dl_q[PIX_LAT-1];
  end

  // Colour source selection for the DAC register.
  always_comb begin
`ifdef TEST_PATTERN_EN
    if (test_mode) begin
      colour_s = tap_s[23:0];
    end else begin
      colour_s = {r_int, g_int, b_int};
    end
`else
    colour_s = {r_int, g_int, b_int};
`endif
  end

  // Output-stage next values: polarity, composite sync and blank gating.
  always_comb begin
    hsync_d   = tap_s[PW-2] ? HS_ON : ~HS_ON;
    vsync_d   = tap_s[PW-3] ? VS_ON : ~VS_ON;
    sync_b_d  = ~(tap_s[PW-2] | tap_s[PW-3]);
    blank_b_d = tap_s[PW-1];
    if (tap_s[PW-1]) begin
      rgb_d = colour_s;
    end else begin
      rgb_d = 24'h000000;
    end
  end

  // DAC-side output registers.
  always_ff @(posedge vgaclk) begin
    if (reset) begin
      hsync_q   <= ~HS_ON;
      vsync_q   <= ~VS_ON;
      sync_b_q  <= 1'b1;
      blank_b_q <= 1'b0;
      rgb_q     <= 24'h000000;
    end else begin
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      sync_b_q  <= sync_b_d;
      blank_b_q <= blank_b_d;
      rgb_q     <= rgb_d;
    end
  end

  assign hsync   = hsync_q;
  assign vsync   = vsync_q;
  assign sync_b  = sync_b_q;
  assign blank_b = blank_b_q;
  assign r       = rgb_q[23:16];
  assign g       = rgb_q[15:8];
  assign b       = rgb_q[7:0];

endmodule
